// File: rtl/play_core_multi.sv
// play_core_multi: SDRAM-backed audio block player with rate control, loop, stop and optional re-record
// Build option: define PLAY_REVERSE_EN to add play_reverse (backwards playback, latched at start).
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   play_start/src/dst/...    control from the top controller
//   play_busy/done/pos        status back to the controller
//   play_read/write/addr/...  SDRAM arbiter port (request held until play_sdram_finished)
//   play_audio_*              valid/ready sample stream to the DAC
module play_core_multi #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int RATE_MAX = 2,
  localparam int KW = (RATE_MAX > 0) ? $clog2(RATE_MAX + 1) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_src_base,
  input  logic [ADDR_W-1:0] play_dst_base,
  input  logic              play_record,
  input  logic              play_loop,
  input  logic              play_pause,
  input  logic              play_stop,
  input  logic              play_rate_fast,
  input  logic [KW-1:0]     play_rate_k,
`ifdef PLAY_REVERSE_EN
  input  logic              play_reverse,
`endif
  output logic              play_busy,
  output logic              play_done,
  output logic [ADDR_W-1:0] play_pos,
  output logic              play_read,
  output logic              play_write,
  output logic [ADDR_W-1:0] play_addr,
  output logic [DATA_W-1:0] play_writedata,
  input  logic [DATA_W-1:0] play_readdata,
  input  logic              play_sdram_finished,
  output logic              play_audio_valid,
  output logic [DATA_W-1:0] play_audio_data,
  input  logic              play_audio_ready
);
  typedef enum logic [2:0] {IDLE, RD_LEN, RD_DATA, PLAY, WR_DATA, WR_LEN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] src, dst, n, idx, wcnt, hdr, first;
  logic [DATA_W-1:0] sample;
  logic rec, lp, stop_p, fast, last, stop, beat, play_end, end_blk, fin;
  logic [KW-1:0] k, k_in;
  logic [RATE_MAX:0] bcnt, tgt;
  logic [ADDR_W:0] nxt, step, one;
  assign fin = play_sdram_finished;
  assign hdr = play_readdata[ADDR_W-1:0];
  assign stop = stop_p | play_stop;
  assign k_in = (play_rate_k > KW'(RATE_MAX)) ? KW'(RATE_MAX) : play_rate_k;
  assign tgt = {{RATE_MAX{1'b0}}, 1'b1} << k;
  assign one = {{ADDR_W{1'b0}}, 1'b1};
  assign step = fast ? one << k : one;
  assign beat = (state == PLAY) && !play_pause && play_audio_ready;
  assign play_end = beat && (fast || bcnt == tgt - 1'b1);
`ifdef PLAY_REVERSE_EN
  logic rev;
  logic [ADDR_W-1:0] ld_n;
  // the start index comes from the header word while it is being read, else from the latched N
  assign ld_n = (state == RD_LEN) ? hdr : n;
  assign first = rev ? ld_n - 1'b1 : '0;
  assign nxt = rev ? {1'b0, idx} - step : {1'b0, idx} + step;
  // backwards playback ends on the borrow out of the extended subtraction
  assign end_blk = rev ? nxt[ADDR_W] : (nxt >= {1'b0, n});
`else
  assign first = '0;
  assign nxt = {1'b0, idx} + step;
  assign end_blk = nxt >= {1'b0, n};
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = play_start ? RD_LEN : IDLE;
      RD_LEN:  if (fin) state_n = (stop || hdr == '0) ? (rec ? WR_LEN : IDLE) : RD_DATA;
      RD_DATA: if (fin) state_n = stop ? (rec ? WR_LEN : IDLE) : PLAY;
      PLAY:    if (stop) state_n = rec ? WR_LEN : IDLE;
               else if (play_end) state_n = rec ? WR_DATA : (end_blk && !lp) ? IDLE : RD_DATA;
      WR_DATA: if (fin) state_n = (stop || last) ? WR_LEN : RD_DATA;
      WR_LEN:  if (fin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      play_done <= 1'b0;
      src <= '0;
      dst <= '0;
      n <= '0;
      idx <= '0;
      wcnt <= '0;
      sample <= '0;
      rec <= 1'b0;
      lp <= 1'b0;
      stop_p <= 1'b0;
      fast <= 1'b0;
      last <= 1'b0;
      k <= '0;
      bcnt <= '0;
`ifdef PLAY_REVERSE_EN
      rev <= 1'b0;
`endif
    end else begin
      state <= state_n;
      play_done <= (state != IDLE) && (state_n == IDLE);
      // a stop waits here until the in-flight transaction lets the FSM act on it
      stop_p <= stop && (state != IDLE) && (state != WR_LEN) && (state_n != IDLE) && (state_n != WR_LEN);
      if (state == IDLE && play_start) begin
        src <= play_src_base;
        dst <= play_dst_base;
        rec <= play_record;
        lp <= play_loop && !play_record;
        wcnt <= '0;
`ifdef PLAY_REVERSE_EN
        rev <= play_reverse;
`endif
      end
      if (state == RD_LEN && fin) begin
        n <= hdr;
        idx <= first;
      end
      if (state == RD_DATA && fin) begin
        sample <= play_readdata;
        fast <= play_rate_fast;
        k <= k_in;
        bcnt <= '0;
      end
      if (beat) bcnt <= bcnt + 1'b1;
      if (play_end && !stop) begin
        last <= end_blk;
        idx <= !end_blk ? nxt[ADDR_W-1:0] : lp ? first : idx;
      end
      if (state == WR_DATA && fin) wcnt <= wcnt + 1'b1;
    end
  end
  assign play_busy = state != IDLE;
  assign play_read = (state == RD_LEN) || (state == RD_DATA);
  assign play_write = (state == WR_DATA) || (state == WR_LEN);
  assign play_addr = play_read ? ((state == RD_LEN) ? src : src + idx + ADDR_W'(1)) :
                     play_write ? ((state == WR_LEN) ? dst : dst + wcnt + ADDR_W'(1)) : '0;
  assign play_writedata = (state == WR_LEN) ? DATA_W'(wcnt) : (state == WR_DATA) ? sample : '0;
  assign play_audio_valid = (state == PLAY) && !play_pause;
  assign play_audio_data = sample;
  assign play_pos = idx;
endmodule

// File: tb/tb_play_core_multi.sv
// tb_play_core_multi: directed and randomized checks of play_core_multi against a block-level playback model
module tb_play_core_multi;
  localparam int AW = 23, DW = 32, RM = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic play_start = 1'b0, play_record = 1'b0, play_loop = 1'b0, play_pause = 1'b0;
  logic play_stop = 1'b0, play_rate_fast = 1'b0, play_reverse = 1'b0;
  logic [AW-1:0] play_src_base = '0, play_dst_base = '0;
  logic [1:0] play_rate_k = '0;
  logic play_busy, play_done, play_read, play_write, play_audio_valid;
  logic [AW-1:0] play_pos, play_addr;
  logic [DW-1:0] play_writedata, play_audio_data;
  logic [DW-1:0] play_readdata = '0;
  logic play_sdram_finished = 1'b0, play_audio_ready = 1'b1;
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] aud_q[$], exp_q[$], ws_q[$], wd_q[$];
  logic [AW-1:0] wa_q[$];
  int tests = 0, fails = 0, rd_cnt = 0, lat_min = 0, lat_max = 0, fetched = 0;
  bit rdy_rand = 1'b0;
  time last_beat_t = 0, done_t = 0;

  play_core_multi #(.ADDR_W(AW), .DATA_W(DW), .RATE_MAX(RM)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .play_start(play_start), .play_src_base(play_src_base), .play_dst_base(play_dst_base),
    .play_record(play_record), .play_loop(play_loop), .play_pause(play_pause), .play_stop(play_stop),
    .play_rate_fast(play_rate_fast), .play_rate_k(play_rate_k),
`ifdef PLAY_REVERSE_EN
    .play_reverse(play_reverse),
`endif
    .play_busy(play_busy), .play_done(play_done), .play_pos(play_pos),
    .play_read(play_read), .play_write(play_write), .play_addr(play_addr),
    .play_writedata(play_writedata), .play_readdata(play_readdata),
    .play_sdram_finished(play_sdram_finished),
    .play_audio_valid(play_audio_valid), .play_audio_data(play_audio_data),
    .play_audio_ready(play_audio_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (play_audio_valid && play_audio_ready) begin
      aud_q.push_back(play_audio_data);
      last_beat_t = $time;
    end

  initial forever begin
    @(posedge clk); #1;
    play_audio_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    int wt, lat;
    bit active;
    wt = 0; lat = 0; active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (play_sdram_finished) begin
        play_sdram_finished = 1'b0;
        active = 1'b0;
      end else if (rst_n && (play_read || play_write)) begin
        if (!active) begin
          active = 1'b1;
          wt = 0;
          lat = $urandom_range(lat_max, lat_min);
        end
        if (wt >= lat) begin
          play_sdram_finished = 1'b1;
          if (play_read) begin
            play_readdata = mem[play_addr[9:0]];
            rd_cnt++;
          end else begin
            mem[play_addr[9:0]] = play_writedata;
            wa_q.push_back(play_addr);
            wd_q.push_back(play_writedata);
          end
        end else wt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int src, input int n);
    mem[src] = DW'(n);
    for (int i = 0; i < n; i++) mem[src + 1 + i] = $urandom;
  endtask

  // expected beats and recorded samples straight from the playback rules
  task automatic model(input int src, input bit fast, input int k);
    int n, kk;
    n = int'(mem[src]);
    kk = (k > RM) ? RM : k;
    exp_q.delete();
    ws_q.delete();
    fetched = 0;
    for (int i = 0; i < n; i += fast ? (1 << kk) : 1) begin
      fetched++;
      ws_q.push_back(mem[src + 1 + i]);
      repeat (fast ? 1 : (1 << kk)) exp_q.push_back(mem[src + 1 + i]);
    end
  endtask

  task automatic go(input int src, input int dst, input bit rec, input bit lp, input bit fast, input int k);
    aud_q.delete(); wa_q.delete(); wd_q.delete();
    rd_cnt = 0;
    @(posedge clk); #1;
    play_src_base = AW'(src); play_dst_base = AW'(dst);
    play_record = rec; play_loop = lp; play_rate_fast = fast; play_rate_k = 2'(k);
    play_start = 1'b1;
    @(posedge clk); #1;
    play_start = 1'b0;
    @(negedge clk);
    chk("first_read", {play_read, play_addr}, {1'b1, AW'(src)});
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!play_done && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, 64'(c < 4000), 64'd1);
    chk({tag, "_busy"}, play_busy, 0);
    done_t = $time;
  endtask

  task automatic cmp_audio(input string tag);
    chk({tag, "_nbeats"}, aud_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < aud_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), aud_q[i], exp_q[i]);
  endtask

  task automatic cmp_rec(input string tag, input int dst, input int cnt);
    chk({tag, "_nwr"}, wa_q.size(), cnt + 1);
    for (int i = 0; i < cnt && i < wa_q.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), wa_q[i], dst + 1 + i);
      chk($sformatf("%s_wd%0d", tag, i), wd_q[i], ws_q[i]);
    end
    if (wa_q.size() > cnt) begin
      chk({tag, "_hdr_addr"}, wa_q[cnt], dst);
      chk({tag, "_hdr_len"}, wd_q[cnt], cnt);
    end
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clk);
    chk("rst_outs", {play_busy, play_done, play_read, play_write, play_audio_valid}, 0);
    chk("rst_addr", {play_addr, play_pos}, 0);
    chk("rst_data", {play_writedata, play_audio_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    load(16'h100, 4);
    model(16'h100, 1'b0, 0);
    go(16'h100, 16'h200, 1'b0, 1'b0, 1'b0, 0);
    wait_done("slow_k0");
    cmp_audio("slow_k0");
    chk("done_latency", done_t - last_beat_t, 10);

    model(16'h100, 1'b0, 1);
    go(16'h100, 16'h200, 1'b0, 1'b0, 1'b0, 1);
    wait_done("slow_k1");
    cmp_audio("slow_k1");
    chk("slow_k1_reads", rd_cnt, 5);

    load(16'h140, 5);
    model(16'h140, 1'b1, 1);
    go(16'h140, 16'h200, 1'b0, 1'b0, 1'b1, 1);
    wait_done("fast_k1");
    cmp_audio("fast_k1");

    load(16'h180, 3);
    model(16'h180, 1'b0, 0);
    go(16'h180, 16'h200, 1'b1, 1'b0, 1'b0, 0);
    wait_done("rec3");
    cmp_audio("rec3");
    cmp_rec("rec3", 16'h200, 3);
    chk("rec3_mem_hdr", mem[16'h200], 3);

    lat_min = 3; lat_max = 3;
    go(16'h180, 16'h240, 1'b1, 1'b0, 1'b0, 0);
    c = 0;
    while (!(play_write && play_addr == AW'(16'h242)) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("stop_found_write", 64'(c < 2000), 64'd1);
    @(posedge clk); #1 play_stop = 1'b1;
    @(posedge clk); #1 play_stop = 1'b0;
    wait_done("stop_rec");
    chk("stop_rec_nbeats", aud_q.size(), 2);
    cmp_rec("stop_rec", 16'h240, 2);
    lat_min = 0; lat_max = 0;

    load(16'h1c0, 0);
    go(16'h1c0, 16'h280, 1'b1, 1'b0, 1'b0, 0);
    wait_done("empty_rec");
    chk("empty_rec_nbeats", aud_q.size(), 0);
    ws_q.delete();
    cmp_rec("empty_rec", 16'h280, 0);

    load(16'h300, 2);
    go(16'h300, 16'h200, 1'b0, 1'b1, 1'b0, 0);
    c = 0;
    while (aud_q.size() < 3 && c < 2000) begin @(negedge clk); c++; end
    @(posedge clk); #1 play_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("pause_valid%0d", i), play_audio_valid, 0);
    end
    @(posedge clk); #1 play_pause = 1'b0;
    c = 0;
    while (aud_q.size() < 7 && c < 2000) begin @(negedge clk); c++; end
    chk("loop_enough_beats", 64'(aud_q.size() >= 7), 64'd1);
    @(posedge clk); #1 play_stop = 1'b1;
    @(posedge clk); #1 play_stop = 1'b0;
    wait_done("loop_stop");
    for (int i = 0; i < aud_q.size(); i++)
      chk($sformatf("loop_beat%0d", i), aud_q[i], mem[16'h301 + (i % 2)]);

    rdy_rand = 1'b1; lat_max = 2;
    for (int t = 0; t < 8; t++) begin
      int n, k;
      bit fast, rec;
      n = $urandom_range(1, 10);
      k = $urandom_range(0, 3);
      fast = 1'($urandom_range(0, 1));
      rec = 1'($urandom_range(0, 1));
      load(16'h340, n);
      model(16'h340, fast, k);
      go(16'h340, 16'h3a0, rec, 1'b0, fast, k);
      wait_done($sformatf("rnd%0d", t));
      cmp_audio($sformatf("rnd%0d", t));
      if (rec) cmp_rec($sformatf("rnd%0d", t), 16'h3a0, fetched);
      else chk($sformatf("rnd%0d_nowr", t), wa_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
